// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, parity constants and defaults
// used by both the transmit and receive paths.
package uart_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_t;

   // Parity bit from the XOR of the payload: even keeps it, odd inverts it.
   function automatic logic parity_bit(input logic payload_xor, input logic par_type);
      return (par_type == PAR_ODD) ? ~payload_xor : payload_xor;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts clk cycles while enabled and pulses bit_done on
// the last cycle of each serial bit. prescale must already be >= 1.
module uart_bit_timer #(
   parameter int PRESCALE_WIDTH = 6
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   output logic                      bit_done
);

   logic [PRESCALE_WIDTH-1:0] count;

   assign bit_done = enable && (count == prescale - 1'b1);

   // Cycle counter; restarts at every bit boundary and whenever disabled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (!enable || bit_done) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts a payload on a valid/ready handshake and sends
// start, LSB-first data, optional parity and stop bits on a registered line.
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
   parameter int PRESCALE_WIDTH = 6
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [DATA_WIDTH-1:0]     tx_data,
   input  logic                      tx_valid,
   output logic                      tx_ready,
   input  logic                      par_en,
   input  logic                      par_type,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   output logic                      tx_out,
   output logic                      busy
);

   localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   uart_state_t               state;
   logic [DATA_WIDTH-1:0]     data_q;
   logic                      par_en_q;
   logic                      par_bit_q;
   logic [PRESCALE_WIDTH-1:0] prescale_q;
   logic [IDX_W-1:0]          bit_idx;
   logic                      bit_done;

   assign tx_ready = (state == IDLE);
   assign busy     = (state != IDLE);

   uart_bit_timer #(
      .PRESCALE_WIDTH(PRESCALE_WIDTH)
   ) u_bit_timer (
      .clk     (clk),
      .rst     (rst),
      .enable  (state != IDLE),
      .prescale(prescale_q),
      .bit_done(bit_done)
   );

   // Frame sequencer: accepts a payload, then walks START/DATA/PARITY/STOP
   // one bit period at a time, driving the registered serial line.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: latched payload registers are reset too, so an aborted frame
         // leaves no stale data behind; all state uses <= so every register
         // samples the pre-edge values of the others.
         state      <= IDLE;
         tx_out     <= 1'b1;
         data_q     <= '0;
         par_en_q   <= 1'b0;
         par_bit_q  <= 1'b0;
         prescale_q <= '0;
         bit_idx    <= '0;
      end else begin
         case (state)
            IDLE: begin
               tx_out <= 1'b1;
               if (tx_valid) begin
                  data_q     <= tx_data;
                  par_en_q   <= par_en;
                  par_bit_q  <= parity_bit(^tx_data, par_type);
                  prescale_q <= (prescale == '0) ? PRESCALE_WIDTH'(1) : prescale;
                  bit_idx    <= '0;
                  tx_out     <= 1'b0;
                  state      <= START;
               end
            end
            START: begin
               if (bit_done) begin
                  bit_idx <= '0;
                  tx_out  <= data_q[0];
                  state   <= DATA;
               end
            end
            DATA: begin
               if (bit_done) begin
                  if (bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
                     if (par_en_q) begin
                        tx_out <= par_bit_q;
                        state  <= PARITY;
                     end else begin
                        tx_out <= 1'b1;
                        state  <= STOP;
                     end
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                     tx_out  <= data_q[bit_idx + 1'b1];
                  end
               end
            end
            PARITY: begin
               if (bit_done) begin
                  tx_out <= 1'b1;
                  state  <= STOP;
               end
            end
            STOP: begin
               if (bit_done) begin
                  tx_out <= 1'b1;
                  state  <= IDLE;
               end
            end
            default: begin
               tx_out <= 1'b1;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed frames plus random traffic,
// with a queue-based scoreboard and an independent line monitor.
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] tx_data = '0;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       par_en = 1'b0;
   logic       par_type = 1'b0;
   logic [5:0] prescale = '0;
   logic       tx_out;
   logic       busy;

   uart_tx dut (
      .clk     (clk),
      .rst     (rst),
      .tx_data (tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .par_en  (par_en),
      .par_type(par_type),
      .prescale(prescale),
      .tx_out  (tx_out),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      bit         pe;
      bit         pt;
      int         p;
      int         acc_cyc;
   } frame_t;

   frame_t exp_q[$];
   int     starts[$];
   int     n_checks = 0;
   int     n_fail   = 0;
   int     cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   bit     in_frame    = 0;
   bit     gap_pending = 0;
   int     pos, len, err_cnt;
   frame_t cur;
   bit     bits[$];

   always @(negedge clk) begin
      if (!rst) begin
         in_frame    = 0;
         gap_pending = 0;
         check("reset_tx_out", tx_out, 1);
         check("reset_ready", {tx_ready, busy}, 2'b10);
      end else if (in_frame) begin
         if (tx_out !== bits[pos / cur.p] || busy !== 1'b1) err_cnt++;
         pos++;
         if (pos == len) begin
            check("frame_bits", err_cnt, 0);
            in_frame    = 0;
            gap_pending = 1;
         end
      end else if (gap_pending) begin
         check("idle_gap", {tx_out, tx_ready, busy}, 3'b110);
         gap_pending = 0;
      end else if (tx_out === 1'b0) begin
         if (exp_q.size() == 0) begin
            check("unexpected_start", 1, 0);
         end else begin
            cur = exp_q.pop_front();
            starts.push_back(cyc);
            check("start_latency", cyc, cur.acc_cyc + 1);
            bits.delete();
            bits.push_back(1'b0);
            for (int i = 0; i < 8; i++) bits.push_back(cur.data[i]);
            if (cur.pe) bits.push_back(bit'(($countones(cur.data) % 2) == 1) ^ cur.pt);
            bits.push_back(1'b1);
            len     = bits.size() * cur.p;
            err_cnt = (busy !== 1'b1) ? 1 : 0;
            pos     = 1;
            in_frame = 1;
         end
      end
   end

   // ---------------- stimulus ----------------
   // Called just after a negedge; returns at the negedge after the accept edge.
   task automatic send(input logic [7:0] d, input bit pe, input bit pt,
                       input logic [5:0] ps, input bit hold);
      int budget;
      frame_t f;
      tx_data  = d;
      par_en   = pe;
      par_type = pt;
      prescale = ps;
      tx_valid = 1'b1;
      budget   = 2000;
      while (tx_ready !== 1'b1 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (budget == 0) begin
         check("ready_timeout", 1, 0);
         tx_valid = 1'b0;
         return;
      end
      f.data = d; f.pe = pe; f.pt = pt;
      f.p = (ps == 0) ? 1 : int'(ps);
      f.acc_cyc = cyc;
      exp_q.push_back(f);
      @(negedge clk);
      if (!hold) tx_valid = 1'b0;
      // Disturb inputs mid-frame; the frame in flight must not change.
      tx_data  = 8'($urandom);
      par_en   = 1'($urandom);
      par_type = 1'($urandom);
      prescale = 6'($urandom);
   endtask

   task automatic drain();
      int budget = 5000;
      while ((exp_q.size() != 0 || in_frame || gap_pending) && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      check("drain_timeout", (budget == 0), 0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);

      // Basic frame, no parity, prescale 4 (40-cycle frame).
      send(8'hA5, 0, 0, 6'd4, 0);
      drain();

      // Parity even and odd, prescale 2 (22-cycle frames).
      send(8'h07, 1, 0, 6'd2, 0);
      drain();
      send(8'h07, 1, 1, 6'd2, 0);
      drain();

      // Back-to-back frames with valid held: one idle cycle between them.
      starts.delete();
      send(8'h00, 0, 0, 6'd1, 1);
      send(8'hFF, 0, 0, 6'd1, 0);
      drain();
      check("b2b_count", starts.size(), 2);
      if (starts.size() == 2) check("b2b_spacing", starts[1] - starts[0], 11);

      // prescale 0 behaves as 1; prescale changed mid-frame has no effect.
      send(8'h3C, 1, 0, 6'd0, 0);
      prescale = 6'd9;
      drain();

      // Reset during data bit 3 aborts the frame at once.
      send(8'h96, 0, 0, 6'd4, 0);
      repeat (17) @(negedge clk);
      #2 rst = 1'b0;
      #1 check("async_reset", {tx_out, tx_ready, busy}, 3'b110);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      send(8'h5A, 1, 1, 6'd3, 0);
      drain();

      // Random traffic.
      for (int i = 0; i < 40; i++) begin
         send(8'($urandom), 1'($urandom), 1'($urandom),
              6'($urandom_range(0, 5)), (i != 39) && 1'($urandom));
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
